rr_grant_scheduler: RTL and testbench

//   Round-robin scheduler sharing one resource among 16 requesters on {ui_in, uio_in}.

---
 rtl/rr_grant_scheduler.sv | 116 +++++++++++
 tb/tb_rr_grant_scheduler.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/rr_grant_scheduler.sv
// rtl/rr_grant_scheduler.sv - round-robin grant scheduler for 16 requesters
// Circular descending search from a rotating pointer, held grants, hold-time watchdog.
module rr_grant_scheduler #(
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
  input  logic        release_in,
  output logic        gnt_valid,
  output logic [3:0]  gnt_idx,
  output logic [15:0] gnt_onehot,
  output logic        timeout,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  localparam logic [7:0] MAX_HOLD_W = 8'(MAX_HOLD);

  state_t      state_q, state_d;
  logic [3:0]  ptr_q, ptr_d;
  logic [7:0]  hold_cnt_q, hold_cnt_d;
  logic [3:0]  gnt_idx_q, gnt_idx_d;
  logic        gnt_valid_q, gnt_valid_d;
  logic [15:0] gnt_onehot_q, gnt_onehot_d;
  logic        timeout_q, timeout_d;

  logic [3:0]  win_idx;
  logic        win_found;
  logic        end_normal;
  logic        end_wd;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= 4'd15;
      hold_cnt_q   <= 8'd0;
      gnt_idx_q    <= 4'd0;
      gnt_valid_q  <= 1'b0;
      gnt_onehot_q <= 16'd0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      hold_cnt_q   <= hold_cnt_d;
      gnt_idx_q    <= gnt_idx_d;
      gnt_valid_q  <= gnt_valid_d;
      gnt_onehot_q <= gnt_onehot_d;
      timeout_q    <= timeout_d;
    end
  end

  // Descending search starting at ptr; 4-bit subtraction provides the wrap 0 -> 15.
  always_comb begin
    win_idx   = 4'd0;
    win_found = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (!win_found && req[ptr_q - 4'(i)]) begin
        win_idx   = ptr_q - 4'(i);
        win_found = 1'b1;
      end
    end
  end

  assign end_normal = release_in || !req[gnt_idx_q];
  assign end_wd     = (hold_cnt_q == MAX_HOLD_W);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_found) state_d = GRANT;
      GRANT:   if (end_normal || end_wd) state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ptr_d        = ptr_q;
    hold_cnt_d   = hold_cnt_q;
    gnt_idx_d    = gnt_idx_q;
    gnt_valid_d  = gnt_valid_q;
    gnt_onehot_d = gnt_onehot_q;
    timeout_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          gnt_idx_d    = win_idx;
          gnt_onehot_d = 16'(1) << win_idx;
          gnt_valid_d  = 1'b1;
          hold_cnt_d   = 8'd1;
          ptr_d        = win_idx - 4'd1;
        end
      end
      GRANT: begin
        if (end_normal || end_wd) begin
          gnt_valid_d  = 1'b0;
          gnt_onehot_d = 16'd0;
          // Release has priority over the watchdog, so no pulse on a normal end.
          timeout_d    = !end_normal;
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  assign gnt_valid  = gnt_valid_q;
  assign gnt_idx    = gnt_idx_q;
  assign gnt_onehot = gnt_onehot_q;
  assign timeout    = timeout_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// tb/tb_rr_grant_scheduler.sv - self-checking bench for rr_grant_scheduler
// Directed scenarios followed by randomized traffic against a cycle-level reference model.
module tb_rr_grant_scheduler;

  localparam int MAX_HOLD = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] req = 16'd0;
  logic        release_in = 1'b0;
  logic        gnt_valid;
  logic [3:0]  gnt_idx;
  logic [15:0] gnt_onehot;
  logic        timeout;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 = idle, 1 = granted, 2 = dead cycle
  int m_phase = 0;
  int m_ptr = 15;
  int m_hold = 0;
  int m_idx = 0;
  int m_valid = 0;
  int m_timeout = 0;

  rr_grant_scheduler #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .release_in (release_in),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx),
    .gnt_onehot (gnt_onehot),
    .timeout    (timeout),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int search(input int ptr, input logic [15:0] r);
    for (int k = 0; k < 16; k++) begin
      int c;
      c = (ptr - k + 16) % 16;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_step();
    int w;
    if (!rst_n) begin
      m_phase = 0; m_ptr = 15; m_hold = 0; m_idx = 0; m_valid = 0; m_timeout = 0;
    end else if (m_phase == 0) begin
      m_timeout = 0;
      w = search(m_ptr, req);
      if (w >= 0) begin
        m_idx = w; m_valid = 1; m_hold = 1; m_ptr = (w + 15) % 16; m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (release_in || !req[m_idx]) begin
        m_valid = 0; m_timeout = 0; m_phase = 2;
      end else if (m_hold == MAX_HOLD) begin
        m_valid = 0; m_timeout = 1; m_phase = 2;
      end else begin
        m_hold++;
      end
    end else begin
      m_timeout = 0;
      m_phase = 0;
    end
  endtask

  task automatic tick();
    logic [15:0] exp_oh;
    @(posedge clk);
    model_step();
    #1;
    exp_oh = (m_valid != 0) ? (16'h1 << m_idx) : 16'h0;
    check("gnt_valid", gnt_valid, m_valid);
    check("gnt_idx", gnt_idx, m_idx);
    check("gnt_onehot", gnt_onehot, exp_oh);
    check("timeout", timeout, m_timeout);
    check("busy", busy, m_phase != 0);
  endtask

  task automatic wait_grant();
    for (int i = 0; i < 8 && !gnt_valid; i++) tick();
    check("wait_grant", gnt_valid, 1);
  endtask

  task automatic release_pulse();
    release_in = 1'b1;
    tick();
    release_in = 1'b0;
    tick();
  endtask

  initial begin
    int cnt;
    int seq [3];

    // Reset with every request asserted
    rst_n = 1'b0; req = 16'hFFFF;
    tick(); tick();
    check("rst_ptr", dut.ptr_q, 15);
    check("rst_hold", dut.hold_cnt_q, 0);
    rst_n = 1'b1;
    tick();
    check("first_idx", gnt_idx, 15);
    release_pulse();

    // Single requester, release ends the grant, one dead cycle
    req = 16'h0020;
    tick();
    check("single_idx", gnt_idx, 5);
    check("single_oh", gnt_onehot, 16'h0020);
    release_in = 1'b1;
    tick();
    check("rel_valid", gnt_valid, 0);
    check("rel_busy", busy, 1);
    release_in = 1'b0;
    tick();
    check("gap_done", busy, 0);

    // Full rotation with wrap
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    req = 16'hFFFF;
    for (int e = 16; e >= -1; e--) begin
      if (e == 16) continue;
      wait_grant();
      check("rot_idx", gnt_idx, (e + 16) % 16);
      release_pulse();
    end

    // Grant 4 then a sparse pattern: 0, 15, 4
    req = 16'h0010;
    wait_grant();
    check("g4_idx", gnt_idx, 4);
    release_pulse();
    req = 16'h8011;
    seq[0] = 0; seq[1] = 15; seq[2] = 4;
    for (int k = 0; k < 3; k++) begin
      wait_grant();
      check("sparse_idx", gnt_idx, seq[k]);
      release_pulse();
    end

    // Watchdog revoke after MAX_HOLD cycles
    req = 16'h0200;
    wait_grant();
    cnt = 1;
    for (int i = 0; i < 40 && gnt_valid; i++) begin
      tick();
      if (gnt_valid) cnt++;
    end
    check("wd_len", cnt, MAX_HOLD);
    check("wd_pulse", timeout, 1);
    tick();
    check("wd_pulse_end", timeout, 0);

    // Release in the last allowed cycle beats the watchdog
    wait_grant();
    cnt = 1;
    for (int i = 0; i < 40 && cnt < MAX_HOLD; i++) begin
      tick();
      if (gnt_valid) cnt++;
    end
    release_in = 1'b1;
    tick();
    check("late_rel_to", timeout, 0);
    check("late_rel_valid", gnt_valid, 0);
    release_in = 1'b0;
    tick();

    // Owner drops its request mid-grant
    req = 16'h0300;
    wait_grant();
    tick();
    req = req & ~(16'h1 << gnt_idx);
    tick();
    check("drop_valid", gnt_valid, 0);
    tick();

    // Reset mid-grant
    req = 16'h0040;
    wait_grant();
    tick();
    rst_n = 1'b0;
    tick();
    check("mid_rst_valid", gnt_valid, 0);
    check("mid_rst_to", timeout, 0);
    check("mid_rst_ptr", dut.ptr_q, 15);
    rst_n = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        req = 16'($urandom) & 16'($urandom);
      end
      release_in = ($urandom_range(0, 7) == 0);
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
